fpu_xif_arbiter: RTL
====================

# fpu_xif_arbiter

Shares one rvfpm coprocessor between two CORE-V-XIF requesters (cores/harts) on the issue, commit and result channels. Round-robin issue arbitration with held grants, FPU-side ID remapping through a slot table, a buffered commit path, and result routing back to the owning requester. Sits between the requesters and the rvfpm XIF ports. Memory channels bypass the block and are wired to requester 0.

## Interface
- X_ID_WIDTH, 4: FPU-side ID width; slot count NUM_SLOTS = 2**X_ID_WIDTH.
- REQ_ID_WIDTH, 4: requester-side ID width.
- XLEN, 32: instruction/operand/result width.
- ck  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_issue_valid / req_issue_ready  in/out  2 / 2  per-requester issue handshake.
- req_instr, req_rs, req_mode, req_id  in  2·XLEN, 2·3·XLEN, 2·2, 2·REQ_ID_WIDTH  packed per-requester issue payload.
- req_accept  out  2  routed issue_resp.accept.
- req_commit_valid, req_commit_kill  in  2, 2; req_commit_id  in  2·REQ_ID_WIDTH.
- req_result_valid / req_result_ready  out/in  2 / 2; req_result_id  out  REQ_ID_WIDTH; req_result_data  out  XLEN; req_result_rd  out  5; req_result_we  out  1 (shared, qualified by valid).
- fpu_issue_valid / fpu_issue_ready  out/in  1 / 1; fpu_instr, fpu_rs, fpu_mode, fpu_id  out  XLEN, 3·XLEN, 2, X_ID_WIDTH.
- fpu_accept, fpu_loadstore  in  1, 1  FPU issue response.
- fpu_commit_valid, fpu_commit_kill  out  1, 1; fpu_commit_id  out  X_ID_WIDTH.
- fpu_result_valid / fpu_result_ready  in/out  1 / 1; fpu_result_id  in  X_ID_WIDTH; fpu_result_data, fpu_result_rd, fpu_result_we  in  XLEN, 5, 1.
- occupancy  out  X_ID_WIDTH+1  live slots.
- err_unmatched, err_commit_ovf  out  1, 1  sticky until reset.

## Operation
- Slot entry: valid, owner (0/1), orig_id, committed. Allocate the lowest-index free slot; fpu_id = slot index.
- Issue FSM, states ARB and LOCK. ARB: grant the valid requester; if both valid, grant rr_ptr. Grant asserted without handshake -> LOCK (grant held, payload must stay stable). Handshake -> ARB, rr_ptr = other requester. LOCK exits only on handshake.
- fpu_issue_valid = granted valid & !blocked. blocked = table full, or a live entry matches (owner, orig_id).
- req_issue_ready[g] = fpu_issue_ready & !blocked; ungranted requester sees 0.
- req_accept[g] = fpu_accept, forced 0 when g=1 and fpu_loadstore=1. Slot allocated only on handshake with forced accept = 1.
- Commit: per-requester 1-entry pending register. One pending is drained per cycle to fpu_commit_* after CAM lookup of (owner, orig_id). If both pending, serve the one not served last cycle. An arrival while own pending is full and not draining -> dropped, err_commit_ovf. Lookup miss -> dropped, err_unmatched. Kill frees the slot on the drain cycle; otherwise sets committed.
- Result: slot = fpu_result_id; route to owner with req_result_id = orig_id. fpu_result_ready = req_result_ready[owner]. Handshake frees the slot. Invalid slot -> fpu_result_ready = 1, dropped, err_unmatched.
- Same-cycle free and allocate: allocation uses the pre-free free-list, so the freed slot is not reused that cycle. Full plus a free in the same cycle stays blocked.

## Timing
- Issue, accept and result paths are combinational; no added latency.
- Commit latency: 1 cycle (arrival registered, forwarded the next cycle) when uncontended; 2 cycles when contended.
- Reset values: all outputs 0, table empty, FSM ARB, rr_ptr = 0, pendings empty, error flags 0.
- Reset mid-operation discards all slots; the FPU must be reset in the same window (top-level duty).

## Structure
- Package pa_fpu_arb: NUM_REQ = 2, slot entry struct typedef, FSM state enum.
- Sub-module fpu_slot_table: storage, lowest-free allocator, (owner, orig_id) CAM, alloc/free/commit ports, occupancy.

## Test plan
- Both requesters valid from reset, ready = 1, accept = 1: grants alternate 0,1,0; fpu_id sequence 0,1,2; occupancy 3.
- Requester 0 granted with ready = 0 for 3 cycles while requester 1 valid: grant held on 0, payload stable, requester 1 served after the handshake.
- 16 accepted issues then a 17th: fpu_issue_valid = 0. A result handshake on slot 5 frees it; the next issue gets fpu_id 5 one cycle later.
- Both requesters commit (id 3, id 7) in the same cycle: fpu_commit emitted on consecutive cycles with their slot IDs; no error.
- Kill commit from requester 1 for orig_id 2: the slot frees. A later result with that slot ID -> dropped, err_unmatched = 1.
- Requester 1 issues a loadstore with fpu_accept = 1 and fpu_loadstore = 1: req_accept[1] = 0, no allocation, occupancy unchanged.

Source files
------------

// File: rtl/pa_fpu_arb_pkg.sv
// rtl/pa_fpu_arb_pkg.sv - shared types for the two-requester rvfpm XIF arbiter
package pa_fpu_arb;

  localparam int NUM_REQ   = 2;
  localparam int ORIG_ID_W = 16;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_e;

  // orig_id is stored zero-extended so the struct does not depend on block parameters
  typedef struct packed {
    logic                 valid;
    logic                 owner;
    logic [ORIG_ID_W-1:0] orig_id;
    logic                 committed;
  } slot_t;

endpackage

// File: rtl/fpu_slot_table.sv
// rtl/fpu_slot_table.sv - FPU-side ID slot table with lowest-free allocator and (owner, orig_id) CAM
module fpu_slot_table
  import pa_fpu_arb::*;
#(
  parameter int SLOT_W       = 4,
  parameter int REQ_ID_WIDTH = 4
) (
  input  logic                    ck,
  input  logic                    rst,
  input  logic                    alloc_en,
  input  logic                    alloc_owner,
  input  logic [REQ_ID_WIDTH-1:0] alloc_orig_id,
  output logic [SLOT_W-1:0]       alloc_idx,
  output logic                    full,
  input  logic                    free_a_en,
  input  logic [SLOT_W-1:0]       free_a_idx,
  input  logic                    free_b_en,
  input  logic [SLOT_W-1:0]       free_b_idx,
  input  logic                    cmt_en,
  input  logic [SLOT_W-1:0]       cmt_idx,
  input  logic                    iss_owner,
  input  logic [REQ_ID_WIDTH-1:0] iss_orig_id,
  output logic                    iss_hit,
  input  logic                    cam_owner,
  input  logic [REQ_ID_WIDTH-1:0] cam_orig_id,
  output logic                    cam_hit,
  output logic [SLOT_W-1:0]       cam_idx,
  input  logic [SLOT_W-1:0]       rd_idx,
  output slot_t                   rd_entry,
  output logic [SLOT_W:0]         occupancy
);

  localparam int NUM_SLOTS = 2 ** SLOT_W;

  slot_t slots [NUM_SLOTS];

  // descending scan so the lowest free index wins
  always_comb begin
    alloc_idx = '0;
    full      = 1'b1;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!slots[i].valid) begin
        alloc_idx = SLOT_W'(i);
        full      = 1'b0;
      end
    end
  end

  always_comb begin
    iss_hit   = 1'b0;
    cam_hit   = 1'b0;
    cam_idx   = '0;
    occupancy = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      occupancy = occupancy + (SLOT_W + 1)'(slots[i].valid);
      if (slots[i].valid && slots[i].owner == iss_owner &&
          slots[i].orig_id == ORIG_ID_W'(iss_orig_id))
        iss_hit = 1'b1;
      if (slots[i].valid && slots[i].owner == cam_owner &&
          slots[i].orig_id == ORIG_ID_W'(cam_orig_id)) begin
        cam_hit = 1'b1;
        cam_idx = SLOT_W'(i);
      end
    end
  end

  assign rd_entry = slots[rd_idx];

  // alloc_idx comes from the pre-free view, so it never collides with a slot freed this cycle
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) slots[i] <= '0;
    end else begin
      if (cmt_en) slots[cmt_idx].committed <= 1'b1;
      if (free_a_en) slots[free_a_idx] <= '0;
      if (free_b_en) slots[free_b_idx] <= '0;
      if (alloc_en) begin
        slots[alloc_idx].valid     <= 1'b1;
        slots[alloc_idx].owner     <= alloc_owner;
        slots[alloc_idx].orig_id   <= ORIG_ID_W'(alloc_orig_id);
        slots[alloc_idx].committed <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fpu_xif_arbiter.sv
// rtl/fpu_xif_arbiter.sv - shares one rvfpm XIF coprocessor between two requesters
module fpu_xif_arbiter
  import pa_fpu_arb::*;
#(
  parameter int X_ID_WIDTH   = 4,
  parameter int REQ_ID_WIDTH = 4,
  parameter int XLEN         = 32
) (
  input  logic                         ck,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_issue_valid,
  output logic [NUM_REQ-1:0]           req_issue_ready,
  input  logic [2*XLEN-1:0]            req_instr,
  input  logic [6*XLEN-1:0]            req_rs,
  input  logic [3:0]                   req_mode,
  input  logic [2*REQ_ID_WIDTH-1:0]    req_id,
  output logic [NUM_REQ-1:0]           req_accept,
  input  logic [NUM_REQ-1:0]           req_commit_valid,
  input  logic [NUM_REQ-1:0]           req_commit_kill,
  input  logic [2*REQ_ID_WIDTH-1:0]    req_commit_id,
  output logic [NUM_REQ-1:0]           req_result_valid,
  input  logic [NUM_REQ-1:0]           req_result_ready,
  output logic [REQ_ID_WIDTH-1:0]      req_result_id,
  output logic [XLEN-1:0]              req_result_data,
  output logic [4:0]                   req_result_rd,
  output logic                         req_result_we,
  output logic                         fpu_issue_valid,
  input  logic                         fpu_issue_ready,
  output logic [XLEN-1:0]              fpu_instr,
  output logic [3*XLEN-1:0]            fpu_rs,
  output logic [1:0]                   fpu_mode,
  output logic [X_ID_WIDTH-1:0]        fpu_id,
  input  logic                         fpu_accept,
  input  logic                         fpu_loadstore,
  output logic                         fpu_commit_valid,
  output logic                         fpu_commit_kill,
  output logic [X_ID_WIDTH-1:0]        fpu_commit_id,
  input  logic                         fpu_result_valid,
  output logic                         fpu_result_ready,
  input  logic [X_ID_WIDTH-1:0]        fpu_result_id,
  input  logic [XLEN-1:0]              fpu_result_data,
  input  logic [4:0]                   fpu_result_rd,
  input  logic                         fpu_result_we,
  output logic [X_ID_WIDTH:0]          occupancy,
  output logic                         err_unmatched,
  output logic                         err_commit_ovf
);

  arb_state_e state_q, state_d;
  logic rr_q, rr_d, gnt_q, gnt_d;
  logic granted, gnt, blocked, full, issue_hit, iss_hs, acc_fwd, alloc_en, rdy_fwd;
  logic [X_ID_WIDTH-1:0]   alloc_idx;
  logic [REQ_ID_WIDTH-1:0] gnt_id;

  logic [NUM_REQ-1:0]      pend_v_q, pend_kill_q, drain_oh;
  logic [REQ_ID_WIDTH-1:0] pend_id_q [NUM_REQ];
  logic                    last_srv_q, drain_any, drain_sel, cam_hit;
  logic [X_ID_WIDTH-1:0]   cam_idx;

  slot_t rd_entry;
  logic  res_route, res_drop, res_hs, unused_entry;

  always_comb begin
    granted = 1'b0;
    gnt     = 1'b0;
    if (state_q == ST_LOCK) begin
      granted = 1'b1;
      gnt     = gnt_q;
    end else begin
      granted = |req_issue_valid;
      gnt     = (&req_issue_valid) ? rr_q : req_issue_valid[1];
    end
  end

  assign gnt_id          = gnt ? req_id[2*REQ_ID_WIDTH-1:REQ_ID_WIDTH] : req_id[REQ_ID_WIDTH-1:0];
  assign blocked         = full | issue_hit;
  assign rdy_fwd         = fpu_issue_ready & ~blocked;
  assign fpu_issue_valid = granted & req_issue_valid[gnt] & ~blocked;
  assign req_issue_ready = granted ? (gnt ? {rdy_fwd, 1'b0} : {1'b0, rdy_fwd}) : 2'b00;
  // requester 1 has no memory channel, so its loadstore offloads are refused
  assign acc_fwd         = fpu_accept & ~(gnt & fpu_loadstore);
  assign req_accept      = granted ? (gnt ? {acc_fwd, 1'b0} : {1'b0, acc_fwd}) : 2'b00;
  assign iss_hs          = fpu_issue_valid & fpu_issue_ready;
  assign alloc_en        = iss_hs & acc_fwd;
  assign fpu_id          = alloc_idx;
  assign fpu_instr       = gnt ? req_instr[2*XLEN-1:XLEN] : req_instr[XLEN-1:0];
  assign fpu_rs          = gnt ? req_rs[6*XLEN-1:3*XLEN] : req_rs[3*XLEN-1:0];
  assign fpu_mode        = gnt ? req_mode[3:2] : req_mode[1:0];

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    if (iss_hs) begin
      state_d = ST_ARB;
      rr_d    = ~gnt;
    end else if (granted) begin
      state_d = ST_LOCK;
      gnt_d   = gnt;
    end
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state_q <= ST_ARB;
      rr_q    <= 1'b0;
      gnt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
    end
  end

  assign drain_any        = |pend_v_q;
  assign drain_sel        = (&pend_v_q) ? ~last_srv_q : pend_v_q[1];
  assign drain_oh         = drain_any ? (drain_sel ? 2'b10 : 2'b01) : 2'b00;
  assign fpu_commit_valid = drain_any & cam_hit;
  assign fpu_commit_kill  = fpu_commit_valid & pend_kill_q[drain_sel];
  assign fpu_commit_id    = cam_idx;

  assign res_route        = fpu_result_valid & rd_entry.valid;
  assign res_drop         = fpu_result_valid & ~rd_entry.valid;
  assign res_hs           = res_route & req_result_ready[rd_entry.owner];
  assign fpu_result_ready = res_drop | res_hs;
  assign req_result_valid = res_route ? (rd_entry.owner ? 2'b10 : 2'b01) : 2'b00;
  assign req_result_id    = res_route ? rd_entry.orig_id[REQ_ID_WIDTH-1:0] : '0;
  assign req_result_data  = res_route ? fpu_result_data : '0;
  assign req_result_rd    = res_route ? fpu_result_rd : '0;
  assign req_result_we    = res_route & fpu_result_we;
  assign unused_entry     = ^rd_entry;

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      pend_v_q       <= '0;
      pend_kill_q    <= '0;
      last_srv_q     <= 1'b1;
      err_unmatched  <= 1'b0;
      err_commit_ovf <= 1'b0;
      for (int r = 0; r < NUM_REQ; r++) pend_id_q[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if (req_commit_valid[r] && pend_v_q[r] && !drain_oh[r]) begin
          err_commit_ovf <= 1'b1;
        end else if (req_commit_valid[r]) begin
          pend_v_q[r]    <= 1'b1;
          pend_kill_q[r] <= req_commit_kill[r];
          pend_id_q[r]   <= req_commit_id[r*REQ_ID_WIDTH +: REQ_ID_WIDTH];
        end else if (drain_oh[r]) begin
          pend_v_q[r] <= 1'b0;
        end
      end
      if (drain_any) last_srv_q <= drain_sel;
      if ((drain_any && !cam_hit) || res_drop) err_unmatched <= 1'b1;
    end
  end

  fpu_slot_table #(
    .SLOT_W      (X_ID_WIDTH),
    .REQ_ID_WIDTH(REQ_ID_WIDTH)
  ) u_slots (
    .ck           (ck),
    .rst          (rst),
    .alloc_en     (alloc_en),
    .alloc_owner  (gnt),
    .alloc_orig_id(gnt_id),
    .alloc_idx    (alloc_idx),
    .full         (full),
    .free_a_en    (fpu_commit_kill),
    .free_a_idx   (cam_idx),
    .free_b_en    (res_hs),
    .free_b_idx   (fpu_result_id),
    .cmt_en       (fpu_commit_valid & ~fpu_commit_kill),
    .cmt_idx      (cam_idx),
    .iss_owner    (gnt),
    .iss_orig_id  (gnt_id),
    .iss_hit      (issue_hit),
    .cam_owner    (drain_sel),
    .cam_orig_id  (pend_id_q[drain_sel]),
    .cam_hit      (cam_hit),
    .cam_idx      (cam_idx),
    .rd_idx       (fpu_result_id),
    .rd_entry     (rd_entry),
    .occupancy    (occupancy)
  );

endmodule
